exp_rom_loader: RTL and testbench

Sequences host ROM downloads into SDRAM for the Amstrad CPC core. It accepts the byte stream from the HPS download channel and throttles it with a wait handshake. Each byte is written to SDRAM on the `ce_ref` slot, mirrored into the second model bank when required. The block keeps a 256-entry bitmap of populated upper-ROM pages, which the CPU read path uses to mask empty ROM slots to 0xFF.

---
 rtl/cpc_loader_pkg.sv | 43 ++++
 rtl/ext_page_decode.sv | 23 ++
 rtl/exp_rom_loader.sv | 194 +++++++++++++++++++
 tb/tb_exp_rom_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_loader_pkg.sv
// Shared types and constants for the CPC ROM download loader.
// Page numbers are 9 bits: bit 8 selects the upper-ROM region.
package cpc_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WRITE,
    S_MIRROR
  } state_e;

  localparam logic [8:0] PAGE_BOOT0 = 9'h000;
  localparam logic [8:0] PAGE_BOOT1 = 9'h100;
  localparam logic [8:0] PAGE_BOOT2 = 9'h107;
  localparam logic [8:0] PAGE_BOOT3 = 9'h1FF;
  localparam logic [8:0] PAGE_BAD   = 9'h1EE;

  localparam logic [7:0] CHR_Z = 8'h5A;
  localparam logic [7:0] CHR_0 = 8'h30;

  // {valid, value} for one ASCII hex digit (upper case only)
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  function automatic logic [8:0] boot_page(input logic [1:0] blk);
    logic [8:0] p;
    unique case (blk)
      2'd0: p = PAGE_BOOT0;
      2'd1: p = PAGE_BOOT1;
      2'd2: p = PAGE_BOOT2;
      default: p = PAGE_BOOT3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ext_page_decode.sv
// Two-character file extension to upper-ROM page decode.
// Also flags the special "ZZ" and "Z0" extensions.
module ext_page_decode
  import cpc_loader_pkg::*;
(
  input  logic [15:0] ext_i,
  output logic        valid_o,
  output logic [7:0]  page_o,
  output logic        zz_o,
  output logic        z0_o
);

  logic [4:0] hi;
  logic [4:0] lo;

  assign hi      = hex_nib(ext_i[15:8]);
  assign lo      = hex_nib(ext_i[7:0]);
  assign valid_o = hi[4] & lo[4];
  assign page_o  = {hi[3:0], lo[3:0]};
  assign zz_o    = (ext_i == {CHR_Z, CHR_Z});
  assign z0_o    = (ext_i == {CHR_Z, CHR_0});

endmodule

// File: rtl/exp_rom_loader.sv
// HPS download stream to SDRAM writer with bank mirroring
// and a bitmap of populated upper-ROM pages.
module exp_rom_loader
  import cpc_loader_pkg::*;
#(
  parameter int MAP_PAGES = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_ref,
  input  logic        dl_active,
  input  logic [7:0]  dl_index,
  input  logic [15:0] dl_ext,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        mem_wr,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank,
  output logic [7:0]  mem_din,
  input  logic [7:0]  map_addr,
  output logic        map_hit,
  output logic        busy
);

  state_e state_q, state_d;

  logic [8:0]  page_q, page_d;
  logic        combo_q, combo_d;
  logic        act_q;
  logic        pend_q, pend_d;
  logic        mem_wr_q, mem_wr_d;
  logic        wait_q, wait_d;
  logic [22:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic [7:0]  din_q, din_d;
  logic        mirror_q, mirror_d;
  logic [MAP_PAGES-1:0] map_q, map_d;
  logic        hit_q;

  logic        dec_valid, dec_zz, dec_z0;
  logic [7:0]  dec_page;

  ext_page_decode u_dec (
    .ext_i   (dl_ext),
    .valid_o (dec_valid),
    .page_o  (dec_page),
    .zz_o    (dec_zz),
    .z0_o    (dec_z0)
  );

  logic [10:0] blk;
  logic        is_boot, drop, accept;
  logic        rise, latch_go, done;
  logic [8:0]  wr_page;
  logic [1:0]  wr_bank;
  logic        wr_mirror;

  assign blk     = dl_addr[24:14];
  assign is_boot = (dl_index == 8'd0);
  assign drop    = is_boot & (|blk[10:3]);
  assign accept  = dl_wr & ~drop;
  assign rise    = dl_active & ~act_q;
  assign latch_go = (state_q == S_IDLE) &
                    ((rise & |dl_index) | pend_q);

  always_comb begin
    wr_page   = boot_page(blk[1:0]);
    wr_bank   = {1'b0, blk[2]};
    wr_mirror = 1'b0;
    if (!is_boot) begin
      wr_bank   = {1'b0, &dl_index[7:6]};
      wr_mirror = ~wr_bank[0] &
                  ((dl_index[7:6] == 2'b01) | (|dl_index[5:0]));
      if (combo_q)
        wr_page = (|blk) ? PAGE_BOOT3 : PAGE_BOOT0;
      else
        wr_page = page_q + {1'b0, dl_addr[21:14]};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ARM;
      S_ARM:    if (ce_ref) state_d = S_WRITE;
      S_WRITE:  if (ce_ref) state_d = mirror_q ? S_MIRROR : S_IDLE;
      S_MIRROR: if (ce_ref) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr_d = mem_wr_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    din_d    = din_q;
    mirror_d = mirror_q;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        addr_d   = {wr_page, dl_addr[13:0]};
        bank_d   = wr_bank;
        din_d    = dl_data;
        mirror_d = wr_mirror;
        wait_d   = 1'b1;
      end
      S_ARM: if (ce_ref) mem_wr_d = 1'b1;
      S_WRITE: if (ce_ref) begin
        if (mirror_q) begin
          bank_d = 2'd1;
        end else begin
          mem_wr_d = 1'b0;
          wait_d   = 1'b0;
          done     = 1'b1;
        end
      end
      S_MIRROR: if (ce_ref) begin
        mem_wr_d = 1'b0;
        wait_d   = 1'b0;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    map_d = map_q;
    if (done && addr_q[22]) map_d[addr_q[21:14]] = 1'b1;
  end

  // Edges seen while busy are held and applied on return to idle
  always_comb begin
    page_d  = page_q;
    combo_d = combo_q;
    pend_d  = pend_q;
    if (rise && |dl_index && state_q != S_IDLE)
      pend_d = 1'b1;
    else if (latch_go)
      pend_d = 1'b0;
    if (latch_go) begin
      combo_d = dec_z0;
      if (dec_zz || dec_z0) page_d = PAGE_BOOT0;
      else if (dec_valid)   page_d = {1'b1, dec_page};
      else                  page_d = PAGE_BAD;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      page_q   <= '0;
      combo_q  <= 1'b0;
      act_q    <= 1'b0;
      pend_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      wait_q   <= 1'b0;
      addr_q   <= '0;
      bank_q   <= '0;
      din_q    <= '0;
      mirror_q <= 1'b0;
      map_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      page_q   <= page_d;
      combo_q  <= combo_d;
      act_q    <= dl_active;
      pend_q   <= pend_d;
      mem_wr_q <= mem_wr_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      din_q    <= din_d;
      mirror_q <= mirror_d;
      map_q    <= map_d;
      hit_q    <= map_q[map_addr];
    end
  end

  assign dl_wait  = wait_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = addr_q;
  assign mem_bank = bank_q;
  assign mem_din  = din_q;
  assign map_hit  = hit_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_exp_rom_loader.sv
// Scoreboard bench for exp_rom_loader: random downloads checked
// against a page/bank model; a monitor checks every SDRAM write.
module tb_exp_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_ref;
  logic        dl_active = 1'b0;
  logic [7:0]  dl_index = '0;
  logic [15:0] dl_ext = '0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_wait, mem_wr, map_hit, busy;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_din;
  logic [7:0]  map_addr = '0;
  logic [3:0]  ce_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) ce_cnt <= ce_cnt + 4'd1;
  assign ce_ref = (ce_cnt == 4'd15);

  exp_rom_loader dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_ref(ce_ref),
    .dl_active(dl_active), .dl_index(dl_index), .dl_ext(dl_ext),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wait(dl_wait), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_bank(mem_bank), .mem_din(mem_din),
    .map_addr(map_addr), .map_hit(map_hit), .busy(busy)
  );

  typedef struct {
    logic [22:0] addr;
    logic [1:0]  bank;
    logic [7:0]  din;
  } exp_t;

  exp_t q[$];
  bit   m_map[256];
  int   m_base = 0;
  bit   m_combo = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int cval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  function automatic void model_file(input logic [7:0] idx,
                                     input logic [15:0] ext);
    int h, l;
    if (idx == 0) return;
    m_combo = 0;
    h = cval(ext[15:8]);
    l = cval(ext[7:0]);
    if (ext == 16'h5A5A) m_base = 0;
    else if (ext == 16'h5A30) begin m_base = 0; m_combo = 1; end
    else if (h >= 0 && l >= 0) m_base = 256 + h * 16 + l;
    else m_base = 'h1EE;
  endfunction

  // Reference mapping straight from the page/bank rules
  function automatic void model_write(input logic [7:0] idx,
      input logic [24:0] a, input logic [7:0] d,
      output bit drop, output bit mir);
    int blk, pg, bk;
    int bp[4] = '{0, 'h100, 'h107, 'h1FF};
    exp_t e;
    drop = 0;
    mir = 0;
    blk = int'(a) / 16384;
    if (idx == 0) begin
      if (blk > 7) begin drop = 1; return; end
      pg = bp[blk % 4];
      bk = blk / 4;
    end else begin
      bk = (idx >= 192) ? 1 : 0;
      if (m_combo) pg = (int'(a) < 'h4000) ? 0 : 'h1FF;
      else pg = (m_base + (blk % 256)) % 512;
      mir = (bk == 0) && ((idx / 64 == 1) || (idx % 64 != 0));
    end
    e.addr = 23'(pg * 16384 + int'(a) % 16384);
    e.bank = 2'(bk);
    e.din = d;
    q.push_back(e);
    if (mir) begin e.bank = 2'd1; q.push_back(e); end
    if (pg >= 256) m_map[pg - 256] = 1;
  endfunction

  // Monitor: each bank period of mem_wr is one write
  bit          prev_wr = 0;
  logic [1:0]  prev_bank = '0;
  int          seg_len = 0;
  logic [30:0] seg_val = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_wr = 0;
      seg_len = 0;
    end else begin
      if (mem_wr && (!prev_wr || mem_bank != prev_bank)) begin
        if (prev_wr) chk("wr_len", seg_len, 16);
        if (q.size() == 0) begin
          chk("unexpected_wr", {mem_bank, mem_addr}, 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_bank", mem_bank, e.bank);
          chk("wr_din", mem_din, e.din);
        end
        seg_len = 1;
        seg_val = {mem_addr, mem_din};
      end else if (mem_wr) begin
        seg_len++;
        chk("wr_stable", {mem_addr, mem_din}, seg_val);
      end else if (prev_wr) begin
        chk("wr_len", seg_len, 16);
      end
      prev_wr = mem_wr;
      prev_bank = mem_bank;
    end
  end

  task automatic start_file(input logic [7:0] idx,
                            input logic [15:0] ext);
    @(posedge clk); #1;
    dl_active = 0;
    @(posedge clk); #1;
    dl_index = idx;
    dl_ext = ext;
    dl_active = 1;
    model_file(idx, ext);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [7:0] d,
                          input bit relatch, input logic [15:0] nx);
    bit drop, mir, seen;
    int cnt;
    model_write(dl_index, a, d, drop, mir);
    @(posedge clk); #1;
    dl_addr = a;
    dl_data = d;
    dl_wr = 1;
    @(posedge clk); #1;
    dl_wr = 0;
    if (drop) begin
      seen = 0;
      repeat (40) begin
        if (dl_wait || busy) seen = 1;
        @(posedge clk); #1;
      end
      chk("drop_no_wait", seen, 0);
      return;
    end
    chk("wait_rise", dl_wait, 1);
    chk("busy_rise", busy, 1);
    cnt = 0;
    if (relatch) begin
      @(posedge clk); #1;
      dl_active = 0;
      @(posedge clk); #1;
      dl_ext = nx;
      dl_active = 1;
      cnt = 2;
    end
    while (dl_wait && cnt < 60) begin
      dl_wr = ($urandom_range(0, 9) == 0);
      if (dl_wr) begin
        dl_addr = 25'($urandom);
        dl_data = 8'($urandom);
      end
      @(posedge clk); #1;
      dl_wr = 0;
      cnt++;
    end
    if (mir) chk("hold_mirror", (cnt > 32 && cnt <= 48), 1);
    else     chk("hold_single", (cnt > 16 && cnt <= 32), 1);
    if (relatch) model_file(dl_index, nx);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [7:0] a);
    @(posedge clk); #1;
    map_addr = a;
    @(posedge clk); #1;
    chk($sformatf("map_hit_%02h", a), map_hit, m_map[a]);
  endtask

  function automatic logic [7:0] rnd_hex();
    int v;
    v = $urandom_range(0, 15);
    return 8'(v < 10 ? 48 + v : 55 + v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout reached, run not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ext;
    logic [7:0]  idx;
    logic [24:0] a;
    int sel;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", dl_wait, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_bank", mem_bank, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_hit", map_hit, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1;

    start_file(8'h00, 16'h0000);
    do_write(25'h14010, 8'hA5, 0, 0);
    lookup(8'h00);
    do_write(25'h24000, 8'h11, 0, 0);

    start_file(8'h01, 16'h3037);
    do_write(25'h00123, 8'h5C, 0, 0);
    lookup(8'h07);

    start_file(8'h40, 16'h5A30);
    do_write(25'h03FFF, 8'h01, 0, 0);
    do_write(25'h04000, 8'h02, 0, 0);

    start_file(8'h02, 16'h4731);
    do_write(25'h00055, 8'h77, 0, 0);
    lookup(8'hEE);

    start_file(8'h03, 16'h3130);
    do_write(25'h08001, 8'h33, 1, 16'h3241);
    do_write(25'h0C002, 8'h44, 0, 0);

    for (int f = 0; f < 14; f++) begin
      idx = ($urandom_range(0, 4) == 0) ? 8'h00 :
            8'($urandom_range(1, 255));
      sel = $urandom_range(0, 9);
      if (sel == 0) ext = 16'h5A5A;
      else if (sel == 1) ext = 16'h5A30;
      else if (sel == 2)
        ext = {8'($urandom_range(65, 90)), rnd_hex()};
      else ext = {rnd_hex(), rnd_hex()};
      start_file(idx, ext);
      for (int w = 0; w < $urandom_range(1, 4); w++) begin
        if (idx == 0) a = 25'($urandom_range(0, 'h3FFFF));
        else if ($urandom_range(0, 2) == 0)
          a = 25'($urandom_range(0, 'h7FFF));
        else a = 25'($urandom);
        do_write(a, 8'($urandom), 0, 0);
      end
    end

    for (int p = 0; p < 256; p++) lookup(8'(p));
    chk("queue_drained", q.size(), 0);

    start_file(8'h01, 16'h3435);
    model_file(8'h01, 16'h3435);
    model_write(8'h01, 25'h00321, 8'h99, a[0], a[1]);
    @(posedge clk); #1;
    dl_addr = 25'h00321;
    dl_data = 8'h99;
    dl_wr = 1;
    @(posedge clk); #1;
    dl_wr = 0;
    sel = 0;
    while (!mem_wr && sel < 40) begin
      @(posedge clk); #1;
      sel++;
    end
    chk("reach_write", mem_wr, 1);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("rst_mid_mem_wr", mem_wr, 0);
    chk("rst_mid_wait", dl_wait, 0);
    chk("rst_mid_busy", busy, 0);
    q.delete();
    foreach (m_map[i]) m_map[i] = 0;
    m_base = 0;
    m_combo = 0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1;
    for (int p = 0; p < 256; p += 5) lookup(8'(p));
    lookup(8'h45);
    repeat (20) @(posedge clk);
    chk("no_wr_after_reset", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
